// File: rtl/edge_detector_multi.sv
// Multi-channel synchronised, glitch-filtered edge detector with per-channel saturating counters.
// Define EDGE_STICKY_EN to add per-channel sticky edge flags (ovSticky, cleared by ivStickyClr).

module edge_detector_multi #(
  parameter int unsigned CHANNELS      = 4,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned FILTER_CYCLES = 4,
  parameter int unsigned CNT_WIDTH     = 16
) (
  input  logic                  iClk,
  input  logic                  iReset,
  input  logic                  iCE,
  input  logic [CHANNELS-1:0]   ivSignal,
  input  logic [2*CHANNELS-1:0] ivMode,
  input  logic                  iCntClr,
  input  logic [3:0]            iCntSel,
  output logic [CHANNELS-1:0]   ovLevel,
  output logic [CHANNELS-1:0]   ovPosedge,
  output logic [CHANNELS-1:0]   ovNegedge,
  output logic [CHANNELS-1:0]   ovEdge,
`ifdef EDGE_STICKY_EN
  input  logic [CHANNELS-1:0]   ivStickyClr,
  output logic [CHANNELS-1:0]   ovSticky,
`endif
  output logic [CNT_WIDTH-1:0]  ovCount
);

  // Filter counter holds 0..FILTER_CYCLES-1; reaching FILTER_CYCLES is the accept itself.
  localparam int unsigned FiltW = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
  localparam logic [FiltW-1:0] FiltLast = FiltW'(FILTER_CYCLES - 1);

  logic [SYNC_STAGES-1:0] syncQ   [CHANNELS];
  logic [FiltW-1:0]       filtCnt [CHANNELS];
  logic [CNT_WIDTH-1:0]   edgeCnt [CHANNELS];

  logic [CHANNELS-1:0] sample, accept, riseEn, fallEn, rise, fall;

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      sample[i] = syncQ[i][SYNC_STAGES-1];
      accept[i] = (sample[i] != ovLevel[i]) && (filtCnt[i] == FiltLast);
      riseEn[i] = ivMode[2*i];
      fallEn[i] = ivMode[2*i+1];
    end
    rise = accept & ~ovLevel;
    fall = accept & ovLevel;
  end

  always_ff @(posedge iClk) begin
    if (iReset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        syncQ[i]   <= '0;
        filtCnt[i] <= '0;
        edgeCnt[i] <= '0;
      end
      ovLevel   <= '0;
      ovPosedge <= '0;
      ovNegedge <= '0;
      ovEdge    <= '0;
    end else begin
      if (iCE) begin
        for (int i = 0; i < CHANNELS; i++) begin
          syncQ[i] <= {syncQ[i][SYNC_STAGES-2:0], ivSignal[i]};
          if (sample[i] == ovLevel[i]) begin
            filtCnt[i] <= '0;
          end else if (accept[i]) begin
            filtCnt[i] <= '0;
            ovLevel[i] <= sample[i];
          end else begin
            filtCnt[i] <= filtCnt[i] + FiltW'(1);
          end
        end
        ovPosedge <= rise;
        ovNegedge <= fall;
        ovEdge    <= (rise & riseEn) | (fall & fallEn);
      end else begin
        // Pulses must stay one iClk wide even when iCE is slow.
        ovPosedge <= '0;
        ovNegedge <= '0;
        ovEdge    <= '0;
      end
      for (int i = 0; i < CHANNELS; i++) begin
        if (iCntClr) begin
          edgeCnt[i] <= '0;
        end else if (ovEdge[i] && (edgeCnt[i] != {CNT_WIDTH{1'b1}})) begin
          edgeCnt[i] <= edgeCnt[i] + CNT_WIDTH'(1);
        end
      end
    end
  end

`ifdef EDGE_STICKY_EN
  // Set has priority over clear so an edge is never lost.
  always_ff @(posedge iClk) begin
    if (iReset) begin
      ovSticky <= '0;
    end else begin
      ovSticky <= ovEdge | (ovSticky & ~ivStickyClr);
    end
  end
`endif

  always_comb begin
    ovCount = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (iCntSel == 4'(i)) begin
        ovCount = edgeCnt[i];
      end
    end
  end

endmodule

// File: tb/tb_edge_detector_multi.sv
// Bench for edge_detector_multi: directed scenarios plus randomized run against a window-based model.

module tb_edge_detector_multi;

  localparam int CH = 4;
  localparam int SS = 2;
  localparam int FC = 4;
  localparam int CW = 4;
  localparam int HL = SS + FC;

  logic            iClk = 1'b0;
  logic            iReset, iCE, iCntClr;
  logic [CH-1:0]   ivSignal;
  logic [2*CH-1:0] ivMode;
  logic [3:0]      iCntSel;
  logic [CH-1:0]   ovLevel, ovPosedge, ovNegedge, ovEdge;
  logic [CW-1:0]   ovCount;
`ifdef EDGE_STICKY_EN
  logic [CH-1:0]   ivStickyClr, ovSticky;
`endif

  int nTests = 0;
  int nFail  = 0;

  always #5 iClk = ~iClk;

  edge_detector_multi #(
    .CHANNELS(CH), .SYNC_STAGES(SS), .FILTER_CYCLES(FC), .CNT_WIDTH(CW)
  ) dut (
    .iClk(iClk), .iReset(iReset), .iCE(iCE), .ivSignal(ivSignal), .ivMode(ivMode),
    .iCntClr(iCntClr), .iCntSel(iCntSel), .ovLevel(ovLevel), .ovPosedge(ovPosedge),
    .ovNegedge(ovNegedge), .ovEdge(ovEdge),
`ifdef EDGE_STICKY_EN
    .ivStickyClr(ivStickyClr), .ovSticky(ovSticky),
`endif
    .ovCount(ovCount)
  );

  // Reference model: a level flips once the last FC iCE-samples seen through the synchroniser
  // all disagree with it. hist[c][k] is the raw input captured k+1 iCE edges ago.
  logic [CH-1:0] mLevel, mPos, mNeg, mEdge, mSticky;
  logic [CW-1:0] mCount [CH];
  logic [HL-1:0] hist   [CH];

  task automatic tick();
    logic [CH-1:0] rise, fall;
    logic allDiff;
    @(posedge iClk);
    if (iReset) begin
      mLevel = '0; mPos = '0; mNeg = '0; mEdge = '0; mSticky = '0;
      for (int c = 0; c < CH; c++) begin
        mCount[c] = '0;
        hist[c]   = '0;
      end
    end else begin
      for (int c = 0; c < CH; c++) begin
        if (iCntClr) mCount[c] = '0;
        else if (mEdge[c] && mCount[c] < CW'((1 << CW) - 1)) mCount[c] = mCount[c] + 1'b1;
`ifdef EDGE_STICKY_EN
        if (mEdge[c]) mSticky[c] = 1'b1;
        else if (ivStickyClr[c]) mSticky[c] = 1'b0;
`endif
      end
      rise = '0;
      fall = '0;
      if (iCE) begin
        for (int c = 0; c < CH; c++) begin
          allDiff = 1'b1;
          for (int j = 0; j < FC; j++) if (hist[c][SS + j - 1] == mLevel[c]) allDiff = 1'b0;
          hist[c] = {hist[c][HL-2:0], ivSignal[c]};
          if (allDiff) begin
            rise[c]   = ~mLevel[c];
            fall[c]   = mLevel[c];
            mLevel[c] = ~mLevel[c];
          end
        end
      end
      mPos = rise;
      mNeg = fall;
      for (int c = 0; c < CH; c++) mEdge[c] = (rise[c] & ivMode[2*c]) | (fall[c] & ivMode[2*c+1]);
    end
    #1;
  endtask

  task automatic test_reset();
    int first, n;
    iReset = 1'b1; iCE = 1'b1; ivSignal = '1; ivMode = 8'h55; iCntClr = 1'b0; iCntSel = 4'd0;
`ifdef EDGE_STICKY_EN
    ivStickyClr = '0;
`endif
    repeat (3) tick();
    nTests++;
    if ({ovLevel, ovPosedge, ovNegedge, ovEdge} !== '0) begin
      nFail++;
      $display("FAIL reset_outputs: got %h expected 0", {ovLevel, ovPosedge, ovNegedge, ovEdge});
    end
    nTests++;
    if (ovCount !== '0) begin
      nFail++;
      $display("FAIL reset_count: got %0d expected 0", ovCount);
    end
    iReset = 1'b0;
    first = 0; n = 0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (ovPosedge[0]) begin
        n++;
        if (first == 0) first = k;
      end
    end
    nTests++;
    if (first != 6 || n != 1) begin
      nFail++;
      $display("FAIL reset_held_high: got edge %0d x%0d expected edge 6 x1", first, n);
    end
    ivSignal = '0;
    repeat (12) tick();
  endtask

  task automatic test_posedge();
    int first, nPos, nEdge;
    iCntClr = 1'b1; tick(); iCntClr = 1'b0;
    ivMode = 8'h55; iCntSel = 4'd0; ivSignal[0] = 1'b1;
    first = 0; nPos = 0; nEdge = 0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (ovPosedge[0]) begin
        nPos++;
        if (first == 0) first = k;
      end
      if (ovEdge[0]) nEdge++;
    end
    nTests++;
    if (first != 6 || nPos != 1 || nEdge != 1) begin
      nFail++;
      $display("FAIL posedge_latency: got edge %0d pos %0d edge %0d expected 6 1 1",
               first, nPos, nEdge);
    end
    nTests++;
    if (ovLevel[0] !== 1'b1 || ovCount !== 4'd1) begin
      nFail++;
      $display("FAIL posedge_level_count: got level %b count %0d expected 1 1",
               ovLevel[0], ovCount);
    end
  endtask

  task automatic test_glitch();
    int pulses;
    iCntSel = 4'd1; pulses = 0;
    ivSignal[1] = 1'b1;
    repeat (3) begin
      tick();
      pulses += int'(ovPosedge[1] | ovNegedge[1] | ovEdge[1]);
    end
    ivSignal[1] = 1'b0;
    repeat (12) begin
      tick();
      pulses += int'(ovPosedge[1] | ovNegedge[1] | ovEdge[1]);
    end
    nTests++;
    if (pulses != 0 || ovLevel[1] !== 1'b0 || ovCount !== 4'd0) begin
      nFail++;
      $display("FAIL glitch_reject: got pulses %0d level %b count %0d expected 0 0 0",
               pulses, ovLevel[1], ovCount);
    end
  endtask

  task automatic test_ce_gating();
    int ceN, width, at;
    ivSignal[2] = 1'b1;
    repeat (10) tick();
    ivSignal[2] = 1'b0;
    ceN = 0; width = 0; at = 0;
    for (int k = 0; k < 64; k++) begin
      iCE = (k % 4 == 0);
      tick();
      if (iCE) ceN++;
      if (ovNegedge[2]) begin
        width++;
        at = ceN;
      end
    end
    iCE = 1'b1;
    nTests++;
    if (width != 1 || at != 6 || ovLevel[2] !== 1'b0) begin
      nFail++;
      $display("FAIL ce_negedge: got width %0d at ce %0d level %b expected 1 6 0",
               width, at, ovLevel[2]);
    end
  endtask

  task automatic test_both_modes();
    int nEdge, nPos;
    ivMode = 8'hD5; iCntSel = 4'd3;
    iCntClr = 1'b1; tick(); iCntClr = 1'b0;
    nEdge = 0;
    for (int t = 0; t < 10; t++) begin
      ivSignal[3] = ~ivSignal[3];
      repeat (10) begin
        tick();
        nEdge += int'(ovEdge[3]);
      end
    end
    nTests++;
    if (nEdge != 10 || ovCount !== 4'd10) begin
      nFail++;
      $display("FAIL both_edges: got pulses %0d count %0d expected 10 10", nEdge, ovCount);
    end
    ivMode[7:6] = 2'b00;
    ivSignal[3] = ~ivSignal[3];
    nEdge = 0; nPos = 0;
    repeat (10) begin
      tick();
      nEdge += int'(ovEdge[3]);
      nPos  += int'(ovPosedge[3]);
    end
    nTests++;
    if (nPos != 1 || nEdge != 0 || ovCount !== 4'd10) begin
      nFail++;
      $display("FAIL disabled_mode: got pos %0d edge %0d count %0d expected 1 0 10",
               nPos, nEdge, ovCount);
    end
  endtask

  task automatic test_saturate();
    int nEdge;
    bit found;
    ivMode[1:0] = 2'b11; iCntSel = 4'd0;
    iCntClr = 1'b1; tick(); iCntClr = 1'b0;
    nEdge = 0;
    for (int t = 0; t < 20; t++) begin
      ivSignal[0] = ~ivSignal[0];
      repeat (10) begin
        tick();
        nEdge += int'(ovEdge[0]);
      end
    end
    nTests++;
    if (nEdge != 20 || ovCount !== 4'd15) begin
      nFail++;
      $display("FAIL saturate: got pulses %0d count %0d expected 20 15", nEdge, ovCount);
    end
    iCntSel = 4'd9; #1;
    nTests++;
    if (ovCount !== 4'd0) begin
      nFail++;
      $display("FAIL sel_out_of_range: got %0d expected 0", ovCount);
    end
    iCntSel = 4'd0;
    ivSignal[0] = ~ivSignal[0];
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      tick();
      found = ovEdge[0];
    end
    iCntClr = 1'b1; tick(); iCntClr = 1'b0;
    nTests++;
    if (!found || ovCount !== 4'd0) begin
      nFail++;
      $display("FAIL clear_wins: got found %b count %0d expected 1 0", found, ovCount);
    end
  endtask

  task automatic test_reset_midfilter();
    int first, n;
    ivSignal[1] = 1'b1;
    repeat (5) tick();
    iReset = 1'b1;
    tick();
    nTests++;
    if ({ovLevel, ovPosedge, ovNegedge, ovEdge, ovCount} !== '0) begin
      nFail++;
      $display("FAIL reset_midfilter: got %h expected 0",
               {ovLevel, ovPosedge, ovNegedge, ovEdge, ovCount});
    end
    iReset = 1'b0;
    first = 0; n = 0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (ovPosedge[1]) begin
        n++;
        if (first == 0) first = k;
      end
    end
    nTests++;
    if (first != 6 || n != 1) begin
      nFail++;
      $display("FAIL post_reset_edge: got edge %0d x%0d expected edge 6 x1", first, n);
    end
  endtask

`ifdef EDGE_STICKY_EN
  task automatic test_sticky();
    bit found;
    ivMode[1:0] = 2'b11;
    ivStickyClr = '1; tick(); ivStickyClr = '0;
    ivSignal[0] = ~ivSignal[0];
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      tick();
      found = ovEdge[0];
    end
    ivStickyClr[0] = 1'b1; tick();
    nTests++;
    if (!found || ovSticky[0] !== 1'b1) begin
      nFail++;
      $display("FAIL sticky_set_wins: got found %b sticky %b expected 1 1", found, ovSticky[0]);
    end
    tick();
    ivStickyClr[0] = 1'b0;
    nTests++;
    if (ovSticky[0] !== 1'b0) begin
      nFail++;
      $display("FAIL sticky_clear: got %b expected 0", ovSticky[0]);
    end
  endtask
`endif

  task automatic test_random();
    int bad;
    logic [CW-1:0] expCount;
    bad = 0;
    for (int k = 0; k < 1500; k++) begin
      iCE = ($urandom_range(0, 7) != 0);
      for (int c = 0; c < CH; c++) if ($urandom_range(0, 9) == 0) ivSignal[c] = ~ivSignal[c];
      if ($urandom_range(0, 30) == 0) ivMode = 8'($urandom);
      iCntClr = ($urandom_range(0, 60) == 0);
      iReset  = ($urandom_range(0, 400) == 0);
      iCntSel = 4'($urandom_range(0, 15));
`ifdef EDGE_STICKY_EN
      ivStickyClr = 4'($urandom) & 4'($urandom);
`endif
      tick();
      expCount = (int'(iCntSel) < CH) ? mCount[iCntSel[1:0]] : '0;
      nTests++;
      if ({ovLevel, ovPosedge, ovNegedge, ovEdge, ovCount} !== {mLevel, mPos, mNeg, mEdge, expCount}
`ifdef EDGE_STICKY_EN
          || ovSticky !== mSticky
`endif
          ) begin
        nFail++;
        bad++;
        if (bad <= 10)
          $display("FAIL random_cycle_%0d: got %h expected %h", k,
                   {ovLevel, ovPosedge, ovNegedge, ovEdge, ovCount},
                   {mLevel, mPos, mNeg, mEdge, expCount});
      end
    end
    iReset = 1'b0; iCntClr = 1'b0; iCE = 1'b1;
  endtask

  initial begin
    test_reset();
    test_posedge();
    test_glitch();
    test_ce_gating();
    test_both_modes();
    test_saturate();
    test_reset_midfilter();
`ifdef EDGE_STICKY_EN
    test_sticky();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
